// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential N x N shift-and-add multiplier with start/busy/done handshake
// Define SHIFT_ADD_MULTIPLIER_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned loop).
module shift_add_multiplier #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [2*N-1:0] mcand_q, mcand_d, acc_q, acc_d, result_q, result_d, acc_sum, fin;
  logic [N-1:0] mplier_q, mplier_d, a_mag, b_mag;
  logic [CW-1:0] cnt_q, cnt_d;
  assign acc_sum = mplier_q[0] ? acc_q + mcand_q : acc_q;
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  logic neg_q, neg_d;
  assign a_mag = a[N-1] ? N'(-a) : a;
  assign b_mag = b[N-1] ? N'(-b) : b;
  assign neg_d = (state_q == IDLE && start) ? a[N-1] ^ b[N-1] : neg_q;
  assign fin   = neg_q ? ~acc_sum + 1'b1 : acc_sum;
  always_ff @(posedge clk or posedge rst)
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
`else
  assign a_mag = a;
  assign b_mag = b;
  assign fin   = acc_sum;
`endif
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start) begin
        mcand_d  = {{N{1'b0}}, a_mag};
        mplier_d = b_mag;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = RUN;
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          result_d = fin;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  assign busy   = state_q == RUN;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: random and directed stimulus checked against a cycle-schedule product model
module tb_shift_add_multiplier;
  localparam int N = 4;
  logic clk = 0, rst = 1, start = 0, busy, done;
  logic [N-1:0] a = '0, b = '0;
  logic [2*N-1:0] result, res_exp, pend;
  int total = 0, passed = 0, cyc = 0, acc_cyc = -100, next_ok = 0;
  shift_add_multiplier #(.N(N)) dut (.clk(clk), .rst(rst), .start(start), .a(a), .b(b),
                                     .busy(busy), .done(done), .result(result));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    else passed++;
  endtask
  function automatic logic [2*N-1:0] prod(logic [N-1:0] x, logic [N-1:0] y);
    int sx, sy;
    sx = int'(x);
    sy = int'(y);
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
    if (x[N-1]) sx -= (1 << N);
    if (y[N-1]) sy -= (1 << N);
`endif
    return (2*N)'(sx * sy);
  endfunction
  // Model: accepts when idle long enough, product due N cycles after accept
  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      acc_cyc = -100;
      next_ok = 0;
      res_exp = '0;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
    end else begin
      if (start && cyc >= next_ok) begin
        acc_cyc = cyc;
        next_ok = cyc + N + 2;
        pend = prod(a, b);
      end
      if (cyc == acc_cyc + N) res_exp = pend;
      chk("busy", busy, (cyc >= acc_cyc && cyc < acc_cyc + N) ? 1 : 0);
      chk("done", done, (cyc == acc_cyc + N) ? 1 : 0);
      chk("result", result, res_exp);
    end
  end
`ifdef SHIFT_ADD_MULTIPLIER_SIGNED_EN
  logic [N-1:0] da [4] = '{4'hD, 4'h8, 4'h8, 4'h0};
  logic [N-1:0] db [4] = '{4'h5, 4'h8, 4'h7, 4'hF};
  logic [2*N-1:0] de [4] = '{8'hF1, 8'h40, 8'hC8, 8'h00};
`else
  logic [N-1:0] da [4] = '{4'd15, 4'd0, 4'd9, 4'd12};
  logic [N-1:0] db [4] = '{4'd15, 4'd9, 4'd0, 4'd13};
  logic [2*N-1:0] de [4] = '{8'hE1, 8'h00, 8'h00, 8'h9C};
`endif
  task automatic run_one(logic [N-1:0] x, logic [N-1:0] y, logic [2*N-1:0] e);
    @(negedge clk);
    a = x;
    b = y;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    a = N'($urandom);
    b = N'($urandom);
    repeat (N) @(posedge clk);
    #1;
    chk("const_done", done, 1);
    chk("const_result", result, e);
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_result", result, 0);
    rst = 0;
    for (int i = 0; i < 4; i++) run_one(da[i], db[i], de[i]);
    @(negedge clk);
    a = 3;
    b = 5;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    a = 7;
    b = 7;
    repeat (N) @(posedge clk);
    #1;
    chk("ign_first", result, 8'h0F);
    repeat (N + 2) @(posedge clk);
    #1;
    chk("ign_second", result, 8'h31);
    chk("ign_done", done, 1);
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    a = 12;
    b = 13;
    start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_result", result, 0);
    @(negedge clk);
    rst = 0;
    run_one(da[3], db[3], de[3]);
    repeat (N + 2) @(negedge clk);
    start = 1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a = N'(i >> N);
      b = N'(i);
      @(posedge clk);
      @(negedge clk);
      a = N'($urandom);
      b = N'($urandom);
      repeat (N + 1) @(posedge clk);
    end
    @(negedge clk);
    start = 0;
    repeat (N + 3) @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      a = N'($urandom);
      b = N'($urandom);
      rst = $urandom_range(0, 40) == 0;
    end
    @(negedge clk);
    rst = 0;
    start = 0;
    repeat (N + 3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
